// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
//
// Sequences the instruction-memory write port during program download. A byte
// stream from the host link is packed little-endian into 32-bit words. Each
// word is written to the next word-aligned address. The CPU is held in stall
// until the whole program has been written.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   After the last word, one more byte is accepted. It is compared against the
//   modulo-256 sum of all payload bytes. A match ends in DONE; a mismatch ends
//   in ERROR. Without the macro, the last write goes straight to DONE.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       single-cycle pulse, begins a load of load_len words
//   load_len    number of words to load, sampled when start is accepted
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts byte_in this cycle
//   wr_en       instruction memory write enable (one cycle per word)
//   write_addr  byte address of the word being written, bits [1:0] = 0
//   data_in     word being written
//   cpu_hold    CPU stall/reset hold
//   done        load completed successfully (level)
//   error       load aborted (level)
// ---------------------------------------------------------------------------
module imem_program_loader #(
    parameter  int CAPACITY   = 512,
    parameter  int BUS_WIDTH  = 32,
    localparam int ADDR_WIDTH = $clog2(CAPACITY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH+1:0] write_addr,
    output logic [BUS_WIDTH-1:0]  data_in,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] CAP_LEN = (ADDR_WIDTH + 1)'(CAPACITY);
    localparam logic [ADDR_WIDTH:0] ONE_LEN = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                state_q, state_nx;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           asm_word_q;   // first three bytes of the current word
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
`endif

    logic start_acc;
    logic byte_acc;
    logic last_word;

    // start only counts from a resting state; it is ignored mid-load
    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign byte_acc  = byte_valid && byte_ready;
    assign last_word = (word_idx_q == (len_q - ONE_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_word_q <= '0;
            write_addr <= '0;
            data_in    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q <= state_nx;

            if (start_acc) begin
                len_q      <= load_len;
                word_idx_q <= '0;
                byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end

            if (byte_acc && (state_q == COLLECT)) begin
                byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q      <= sum_q + byte_in;
`endif
                case (byte_idx_q)
                    2'd0: asm_word_q[7:0]   <= byte_in;
                    2'd1: asm_word_q[15:8]  <= byte_in;
                    2'd2: asm_word_q[23:16] <= byte_in;
                    default: begin
                        // Word complete: present it on the write port now so it
                        // is stable during WRITE and holds afterwards.
                        data_in    <= {byte_in, asm_word_q};
                        write_addr <= {word_idx_q[ADDR_WIDTH-1:0], 2'b00};
                    end
                endcase
            end

            if (state_q == WRITE) begin
                word_idx_q <= word_idx_q + ONE_LEN;
            end
        end
    end

    always_comb begin
        state_nx   = state_q;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (state_q == DONE) begin
                    done     = 1'b1;
                    cpu_hold = 1'b0;
                end
                if (state_q == ERROR) begin
                    error = 1'b1;
                end
                if (start_acc) begin
                    if (load_len == '0) begin
                        state_nx = DONE;
                    end else if (load_len > CAP_LEN) begin
                        state_nx = ERROR;
                    end else begin
                        state_nx = COLLECT;
                    end
                end
            end

            COLLECT: begin
                byte_ready = 1'b1;
                if (byte_acc && (byte_idx_q == 2'd3)) begin
                    state_nx = WRITE;
                end
            end

            WRITE: begin
                wr_en = 1'b1;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = COLLECT;
                end
            end

            CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (byte_acc) begin
                    state_nx = (byte_in == sum_q) ? DONE : ERROR;
                end
`else
                // Unreachable without the checksum stage.
                state_nx = IDLE;
`endif
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW+1:0] write_addr;
    logic [31:0]   data_in;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_program_loader #(.CAPACITY(512), .BUS_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .write_addr (write_addr),
        .data_in    (data_in),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled on the falling edge.
    int          nw = 0;
    int          multi_wr = 0;
    int          rdy_in_wr = 0;
    logic        prev_wr = 1'b0;
    logic [31:0] log_addr [600];
    logic [31:0] log_data [600];

    always @(negedge clk) begin
        if (wr_en) begin
            if (nw < 600) begin
                log_addr[nw] = 32'(write_addr);
                log_data[nw] = data_in;
            end
            nw++;
            if (prev_wr) multi_wr++;
            if (byte_ready) rdy_in_wr++;
        end
        prev_wr = wr_en;
    end

    logic [7:0] pay[$];

    task automatic clear_log();
        nw = 0;
        multi_wr = 0;
        rdy_in_wr = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        pay.push_back(w[7:0]);
        pay.push_back(w[15:8]);
        pay.push_back(w[23:16]);
        pay.push_back(w[31:24]);
    endtask

    task automatic append_sum();
        logic [7:0] s;
        s = 8'h00;
        foreach (pay[i]) s = s + pay[i];
        pay.push_back(s);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in = b;
        byte_valid = 1'b1;
        cnt = 0;
        while (!byte_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check("byte_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic send_pay(input int gapmax);
        int g;
        foreach (pay[i]) begin
            g = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
            send_byte(pay[i], g);
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        load_len = (AW + 1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int cnt;
        cnt = 0;
        while (!(done || error) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic two_word_load(input int gapmax, input string tag);
        clear_log();
        pay.delete();
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_sum();
`endif
        do_start(2);
        send_pay(gapmax);
        wait_end();
        check({tag, "_nwrites"}, 32'(nw), 32'd2);
        check({tag, "_addr0"}, log_addr[0], 32'h000);
        check({tag, "_data0"}, log_data[0], 32'h12345678);
        check({tag, "_addr1"}, log_addr[1], 32'h004);
        check({tag, "_data1"}, log_data[1], 32'hDEADBEEF);
        check({tag, "_wr_single"}, 32'(multi_wr), 32'd0);
        check({tag, "_ready_in_write"}, 32'(rdy_in_wr), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_addr", 32'(write_addr), 32'd0);
        check("rst_data", data_in, 32'd0);
        repeat (3) @(negedge clk);
        check("idle_hold", 32'(cpu_hold), 32'd1);

        // Two-word load, stream held valid, then with random stalls
        two_word_load(0, "burst");
        two_word_load(3, "stall");

        // Zero-length load
        clear_log();
        do_start(0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_error", 32'(error), 32'd0);
        check("len0_nwrites", 32'(nw), 32'd0);

        // Oversize load rejected
        clear_log();
        do_start(513);
        check("len513_error", 32'(error), 32'd1);
        check("len513_done", 32'(done), 32'd0);
        check("len513_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        check("len513_nwrites", 32'(nw), 32'd0);

        // Full-capacity load
        clear_log();
        pay.delete();
        for (int i = 0; i < 512; i++) push_word(32'hA5000000 | 32'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_sum();
`endif
        do_start(512);
        send_pay(0);
        wait_end();
        check("full_nwrites", 32'(nw), 32'd512);
        check("full_first_data", log_data[0], 32'hA5000000);
        check("full_last_addr", log_addr[511], 32'h7FC);
        check("full_last_data", log_data[511], 32'hA50001FF);
        check("full_wr_single", 32'(multi_wr), 32'd0);
        check("full_done", 32'(done), 32'd1);

        // Reset mid-load after six bytes of a four-word load
        clear_log();
        pay.delete();
        push_word(32'h44332211);
        push_word(32'h88776655);
        do_start(4);
        for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_nwrites", 32'(nw), 32'd1);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_addr", 32'(write_addr), 32'd0);
        check("midrst_data", data_in, 32'd0);

        clear_log();
        pay.delete();
        push_word(32'hCAFEF00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
        append_sum();
`endif
        do_start(1);
        send_pay(0);
        wait_end();
        check("reload_nwrites", 32'(nw), 32'd1);
        check("reload_addr", log_addr[0], 32'h000);
        check("reload_data", log_data[0], 32'hCAFEF00D);
        check("reload_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accepted
        clear_log();
        pay.delete();
        pay.push_back(8'h01);
        pay.push_back(8'h02);
        pay.push_back(8'h03);
        pay.push_back(8'h04);
        pay.push_back(8'h0A);
        do_start(1);
        send_pay(0);
        wait_end();
        check("csum_ok_data", log_data[0], 32'h04030201);
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_error", 32'(error), 32'd0);

        // Checksum rejected
        clear_log();
        pay[4] = 8'h0B;
        do_start(1);
        send_pay(0);
        wait_end();
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
        check("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
